mac_dot_sequencer: RTL and testbench
====================================

# mac_dot_sequencer

Operand sequencer and result collector wrapped around `top_mac_conventional`. It accepts a valid/ready stream of (w, a, last) operand pairs and drives the MAC's w, a and accu_rst inputs. After a fixed pipeline latency it captures the finished accumulator value z for each dot product into a small result FIFO. Results leave on a valid/ready stream together with the element count of that dot product.

## Interface
- W_WIDTH, 8, weight width (signed); must match the MAC
- A_WIDTH, 8, activation width (unsigned); must match the MAC
- PLUS_WIDTH, 4, accumulator guard bits; Z_WIDTH = W_WIDTH+A_WIDTH+PLUS_WIDTH
- MAC_LAT, 3, cycles from a change on mac_w/mac_a/mac_accu_rst to z reflecting that pair; legal range 1..8
- DEPTH, 2, result FIFO entries; legal range 1..4
- LEN_W, 8, width of the element counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; the same rst also drives top_mac_conventional
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_w  in  W_WIDTH  weight
- in_a  in  A_WIDTH  activation
- in_last  in  1  pair is the final element of its dot product
- mac_w  out  W_WIDTH  registered weight to the MAC
- mac_a  out  A_WIDTH  registered activation to the MAC
- mac_accu_rst  out  1  registered; high on the first pair of each dot product
- mac_z  in  Z_WIDTH  accumulator output from the MAC
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_z  out  Z_WIDTH  dot-product result, passed through without modification
- out_len  out  LEN_W  pairs in this dot product; saturates at 2^LEN_W-1

## Operation
- Accept: a pair is accepted on an edge where in_valid && in_ready.
- in_ready = (credits != 0). It does not depend on in_valid or in_last.
- Credits:
  - Reset value is DEPTH.
  - Decrement on accepting a pair with in_last=1.
  - Increment on an out handshake (out_valid && out_ready).
  - If both happen on the same edge, credits are unchanged.
- Issue on an accepted pair:
  - mac_w <= in_w, mac_a <= in_a.
  - mac_accu_rst <= first_flag.
- Issue with no accepted pair (bubble):
  - mac_w <= 0, mac_a <= 0, mac_accu_rst <= 0.
  - The accumulator adds 0 and keeps its value.
- accu_rst contract: a pair issued with mac_accu_rst=1 restarts the accumulator with that pair's product.
- first_flag:
  - Set on reset.
  - Set after accepting a pair with in_last=1.
  - Cleared after accepting a pair with in_last=0.
  - A single-pair dot product has both accu_rst and last on the same pair.
- Length counter:
  - Loads 1 on a first pair; increments on each later pair; saturates at 2^LEN_W-1.
  - The value including the last pair travels with the last tag.
- Last pipeline: a MAC_LAT-deep shift register of {last, len}, advanced every cycle. Stage 0 is loaded when a pair is issued (tag=in_last); bubbles load tag=0.
- Capture: when the pipeline output tag is 1, push {mac_z, len} into the FIFO on that edge.
  - A push never finds the FIFO full, because of the credits.
  - Push and pop on the same edge are both performed.
- FIFO: in-order. out_valid = not empty; out_z/out_len show the head entry.
- Overflow: the MAC wraps beyond Z_WIDTH; the sequencer passes z unchanged.

## Timing
- Reset values:
  - in_ready=1 (DEPTH>=1), out_valid=0, out_z=0, out_len=0.
  - mac_w=0, mac_a=0, mac_accu_rst=0.
  - first_flag=1, credits=DEPTH, pipeline tags all 0, FIFO empty.
- Reset asserted mid-operation:
  - All in-flight and queued results are discarded.
  - The first pair after reset is a first pair.
- Pair accepted at edge t:
  - mac_* carry it during cycle t+1.
  - mac_z reflects it during cycle t+MAC_LAT; for a last pair it is captured at the end of that cycle.
  - out_valid rises in cycle t+MAC_LAT+1.
- Throughput: one pair per cycle while credits > 0. Back-to-back dot products need no bubble between them.
- in_ready falls in the cycle after the DEPTH-th outstanding last is accepted.
  - It rises in the cycle after an out handshake.
  - A handshake and a last accepted on the same edge keep in_ready unchanged.
- out_* hold stable while out_valid && !out_ready.

## Test plan
- Single dot product:
  - Stimulus: pairs (w,a) = (3,4), (-2,5), (7,1) with last on the third; out_ready=1.
  - Response: mac_accu_rst high only with (3,4); one result, out_z=9, out_len=3, out_valid high exactly 1 cycle, at accept(last)+MAC_LAT+1.
- Back-to-back single-pair dot products:
  - Stimulus: (5,6,last), (-1,255,last), (127,255,last) on consecutive cycles.
  - Response: accu_rst high on all three; results 30, -255, 32385 in order, each with out_len=1.
- Bubbles inside a dot product:
  - Stimulus: (2,2), then 3 idle cycles, then (3,3,last).
  - Response: mac_w/mac_a=0 during the idle cycles; out_z=13, out_len=2.
- Backpressure, DEPTH=2, out_ready=0:
  - Stimulus: three single-pair dot products.
  - Response:
    - in_ready drops after the 2nd last is accepted; the third pair is held.
    - Raise out_ready for 1 cycle: one pop, in_ready returns, the third is accepted.
    - All three results arrive in order.
- Length saturation, LEN_W=2:
  - Stimulus: 5 pairs (1,1) with last on the 5th.
  - Response: out_z=5, out_len=3.
- Reset mid-stream:
  - Stimulus: rst for 1 cycle between two pairs of a 4-pair dot product, with one prior result still queued.
  - Response: FIFO empty, out_valid=0, credits=DEPTH; the next pair carries accu_rst=1.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Operand sequencer and result collector for a pipelined MAC: issues (w, a, accu_rst)
// from a valid/ready pair stream and queues each finished dot product with its length.
module mac_dot_sequencer #(
  parameter int W_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int PLUS_WIDTH = 4,
  parameter int MAC_LAT    = 3,
  parameter int DEPTH      = 2,
  parameter int LEN_W      = 8,
  parameter int Z_WIDTH    = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] in_w,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic               in_last,
  output logic [W_WIDTH-1:0] mac_w,
  output logic [A_WIDTH-1:0] mac_a,
  output logic               mac_accu_rst,
  input  logic [Z_WIDTH-1:0] mac_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Z_WIDTH-1:0] out_z,
  output logic [LEN_W-1:0]   out_len
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [2:0]         credits;
  logic               first_flag;
  logic [LEN_W-1:0]   len_cnt;
  logic [LEN_W-1:0]   cur_len;
  logic               accept;
  logic               push;
  logic               pop;
  logic [MAC_LAT-1:0] tag_pipe;
  logic [LEN_W-1:0]   len_pipe [MAC_LAT];
  logic [Z_WIDTH-1:0] fifo_z   [DEPTH];
  logic [LEN_W-1:0]   fifo_len [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [2:0]         count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Credits reserve a FIFO slot per outstanding dot product, so a capture never overflows.
  assign in_ready  = (credits != 3'd0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign push      = tag_pipe[MAC_LAT-1];
  assign out_z     = fifo_z[rd_ptr];
  assign out_len   = fifo_len[rd_ptr];

  always_comb begin
    cur_len = LEN_W'(1);
    if (first_flag) begin
      cur_len = LEN_W'(1);
    end else if (len_cnt == LEN_MAX) begin
      cur_len = len_cnt;
    end else begin
      cur_len = len_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= DEPTH_C;
    end else begin
      case ({accept && in_last, pop})
        2'b10:   credits <= credits - 3'd1;
        2'b01:   credits <= credits + 3'd1;
        default: credits <= credits;
      endcase
    end
  end

  // Bubbles issue zero operands so the accumulator holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_w        <= {W_WIDTH{1'b0}};
      mac_a        <= {A_WIDTH{1'b0}};
      mac_accu_rst <= 1'b0;
      first_flag   <= 1'b1;
      len_cnt      <= {LEN_W{1'b0}};
    end else if (accept) begin
      mac_w        <= in_w;
      mac_a        <= in_a;
      mac_accu_rst <= first_flag;
      first_flag   <= in_last;
      len_cnt      <= cur_len;
    end else begin
      mac_w        <= {W_WIDTH{1'b0}};
      mac_a        <= {A_WIDTH{1'b0}};
      mac_accu_rst <= 1'b0;
    end
  end

  // The last tag travels alongside the MAC pipeline so it emerges as z becomes final.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= {MAC_LAT{1'b0}};
      for (int i = 0; i < MAC_LAT; i++) begin
        len_pipe[i] <= {LEN_W{1'b0}};
      end
    end else begin
      for (int i = MAC_LAT - 1; i > 0; i--) begin
        tag_pipe[i] <= tag_pipe[i-1];
        len_pipe[i] <= len_pipe[i-1];
      end
      tag_pipe[0] <= accept && in_last;
      len_pipe[0] <= accept ? cur_len : {LEN_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_z[i]   <= {Z_WIDTH{1'b0}};
        fifo_len[i] <= {LEN_W{1'b0}};
      end
    end else begin
      if (push) begin
        fifo_z[wr_ptr]   <= mac_z;
        fifo_len[wr_ptr] <= len_pipe[MAC_LAT-1];
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: emulates the MAC, predicts every output with an
// arithmetic dot-product model, and pins the model with hand-computed results.
module tb_mac_dot_sequencer;

  localparam int W = 8;
  localparam int A = 8;
  localparam int P = 4;
  localparam int LAT = 3;
  localparam int DEP = 2;
  localparam int LW = 2;
  localparam int Z = W + A + P;
  localparam int LEN_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, in_last, out_valid, out_ready, mac_accu_rst;
  logic [W-1:0] in_w, mac_w;
  logic [A-1:0] in_a, mac_a;
  logic [Z-1:0] mac_z, out_z;
  logic [LW-1:0] out_len;

  always #5 clk = ~clk;

  mac_dot_sequencer #(
    .W_WIDTH(W), .A_WIDTH(A), .PLUS_WIDTH(P), .MAC_LAT(LAT), .DEPTH(DEP), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a), .in_last(in_last),
    .mac_w(mac_w), .mac_a(mac_a), .mac_accu_rst(mac_accu_rst), .mac_z(mac_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_len(out_len)
  );

  // MAC stand-in: accumulator register plus one output stage gives z three cycles after issue.
  logic [Z-1:0] prod_z, acc_q, z_q;
  assign prod_z = Z'(int'($signed(mac_w)) * int'(mac_a));
  assign mac_z = z_q;
  always @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      z_q   <= '0;
    end else begin
      acc_q <= mac_accu_rst ? prod_z : acc_q + prod_z;
      z_q   <= acc_q;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: dot products as plain sums, results queued with their visibility edge.
  typedef struct { int z; int len; int avail; } res_t;
  res_t exp_q[$];
  int edge_n = 0;
  int m_credits, m_sum, m_len, m_p;
  bit m_first, m_acc, m_pop, started = 0;
  logic [W-1:0] e_w;
  logic [A-1:0] e_a;
  logic e_rst;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_credits = DEP; m_first = 1; m_sum = 0; m_len = 0;
      e_w = '0; e_a = '0; e_rst = 1'b0;
      exp_q.delete();
    end else begin
      m_acc = in_valid && (m_credits != 0);
      m_pop = (exp_q.size() > 0) && (exp_q[0].avail < edge_n) && out_ready;
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_credits++;
      end
      if (m_acc) begin
        m_p = int'($signed(in_w)) * int'(in_a);
        e_w = in_w; e_a = in_a; e_rst = m_first;
        if (m_first) begin
          m_sum = m_p; m_len = 1;
        end else begin
          m_sum += m_p;
          if (m_len < LEN_MAX) m_len++;
        end
        if (in_last) begin
          exp_q.push_back('{m_sum, m_len, edge_n + LAT});
          m_credits--;
        end
        m_first = in_last;
      end else begin
        e_w = '0; e_a = '0; e_rst = 1'b0;
      end
    end
    edge_n++;
    started = 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_credits != 0});
      chk("mac_w", {24'd0, mac_w}, {24'd0, e_w});
      chk("mac_a", {24'd0, mac_a}, {24'd0, e_a});
      chk("mac_accu_rst", {31'd0, mac_accu_rst}, {31'd0, e_rst});
      if (exp_q.size() > 0 && exp_q[0].avail < edge_n) begin
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_z", {12'd0, out_z}, {12'd0, Z'(exp_q[0].z)});
        chk("out_len", {30'd0, out_len}, 32'(exp_q[0].len));
      end else begin
        chk("out_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  // Log of results actually handed out, for the literal expectations.
  logic [Z-1:0] log_z[$];
  logic [LW-1:0] log_len[$];
  initial forever begin
    @(posedge clk);
    if (!rst && out_valid === 1'b1 && out_ready) begin
      log_z.push_back(out_z);
      log_len.push_back(out_len);
    end
  end

  task automatic lit(input int idx, input int z, input int len);
    if (idx >= log_z.size()) begin
      chk("result_present", 32'(log_z.size()), 32'(idx + 1));
    end else begin
      chk("result_z", {12'd0, log_z[idx]}, {12'd0, Z'(z)});
      chk("result_len", {30'd0, log_len[idx]}, 32'(len));
    end
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic send(input int w, input int a, input bit last);
    in_w = W'(w); in_a = A'(a); in_last = last; in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    in_valid = 1'b0; in_w = '0; in_a = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(3, 4, 0); send(-2, 5, 0); send(7, 1, 1); idle(8);
    lit(0, 9, 3);

    send(5, 6, 1); send(-1, 255, 1); send(127, 255, 1); idle(8);
    lit(1, 30, 1); lit(2, -255, 1); lit(3, 32385, 1);

    send(2, 2, 0); idle(3); send(3, 3, 1); idle(8);
    lit(4, 13, 2);

    out_ready = 1'b0;
    send(10, 1, 1); send(20, 1, 1);
    in_w = W'(30); in_a = A'(1); in_last = 1'b1; in_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    idle(8); out_ready = 1'b1; idle(4);
    lit(5, 10, 1); lit(6, 20, 1); lit(7, 30, 1);

    for (int i = 0; i < 5; i++) send(1, 1, i == 4);
    idle(8);
    lit(8, 5, 3);

    out_ready = 1'b0;
    send(4, 4, 1); idle(6);
    send(1, 1, 0); send(2, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    send(3, 3, 0); send(4, 4, 1); idle(8);
    out_ready = 1'b1; idle(4);
    chk("log_size", 32'(log_z.size()), 32'd10);
    lit(9, 25, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
